// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects the write-back value, registers it, and drives the
// register-file write port and the WB->EX forwarding bus. WB_RETIRE_CNT_EN adds a retire counter.
module mem_wb_stage #(
   parameter int DATA     = 32,
   parameter int REG_ADDR = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall,
   input  logic                flush,
   input  logic                in_valid,
   input  logic [DATA-1:0]     mem_RD,
   input  logic [DATA-1:0]     alu_result,
   input  logic [DATA-1:0]     pc_plus4,
   input  logic [DATA-1:0]     imm,
   input  logic [REG_ADDR-1:0] rd,
   input  logic                regWrite,
   input  logic [1:0]          resultSrc,
   output logic                wb_valid,
   output logic                wb_we,
   output logic [REG_ADDR-1:0] wb_rd,
   output logic [DATA-1:0]     wb_data,
   output logic                fwd_en,
   output logic [REG_ADDR-1:0] fwd_rd,
   output logic [DATA-1:0]     fwd_data,
   output logic [31:0]         retire_cnt
);

   logic                valid_reg;
   logic                we_reg;
   logic [REG_ADDR-1:0] rd_reg;
   logic [DATA-1:0]     data_reg;
   logic [DATA-1:0]     data_next;
   logic                we_next;
   logic                advance;

   // Select ahead of the register so wb_data is a clean flop output.
   always_comb begin
      data_next = alu_result;
      case (resultSrc)
         2'b00:   data_next = alu_result;
         2'b01:   data_next = mem_RD;
         2'b10:   data_next = pc_plus4;
         default: data_next = imm;
      endcase
   end

   // x0 is hard-wired zero, so writes to it are suppressed here rather than in the register file.
   assign we_next = in_valid & regWrite & (rd != '0);
   assign advance = ~flush & ~stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= 1'b0;
         we_reg    <= 1'b0;
         rd_reg    <= '0;
         data_reg  <= '0;
      end else if (flush) begin
         valid_reg <= 1'b0;
         we_reg    <= 1'b0;
         rd_reg    <= '0;
         data_reg  <= '0;
      end else if (!stall) begin
         valid_reg <= in_valid;
         we_reg    <= we_next;
         rd_reg    <= rd;
         data_reg  <= data_next;
      end
   end

   assign wb_valid = valid_reg;
   assign wb_we    = we_reg;
   assign wb_rd    = rd_reg;
   assign wb_data  = data_reg;
   assign fwd_en   = we_reg;
   assign fwd_rd   = rd_reg;
   assign fwd_data = data_reg;

`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_cnt_reg <= '0;
      end else if (advance && in_valid) begin
         retire_cnt_reg <= retire_cnt_reg + 32'd1;
      end
   end

   assign retire_cnt = retire_cnt_reg;
`else
   logic unused_advance;
   assign unused_advance = advance;
   assign retire_cnt     = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: the driver queues expected WB state per edge,
// and a monitor compares after every rising edge.
module tb_mem_wb_stage;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic        in_valid;
   logic [31:0] mem_RD;
   logic [31:0] alu_result;
   logic [31:0] pc_plus4;
   logic [31:0] imm;
   logic [4:0]  rd;
   logic        regWrite;
   logic [1:0]  resultSrc;
   logic        wb_valid;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        fwd_en;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
   logic [31:0] retire_cnt;

   mem_wb_stage #(.DATA(32), .REG_ADDR(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall      (stall),
      .flush      (flush),
      .in_valid   (in_valid),
      .mem_RD     (mem_RD),
      .alu_result (alu_result),
      .pc_plus4   (pc_plus4),
      .imm        (imm),
      .rd         (rd),
      .regWrite   (regWrite),
      .resultSrc  (resultSrc),
      .wb_valid   (wb_valid),
      .wb_we      (wb_we),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .fwd_en     (fwd_en),
      .fwd_rd     (fwd_rd),
      .fwd_data   (fwd_data),
      .retire_cnt (retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [31:0] cnt;
      string       tag;
   } exp_t;

   exp_t        sb_q[$];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, req);
      end
   endtask

   // One edge of stimulus; the expected WB state after that edge goes on the scoreboard.
   task automatic step(input logic st, input logic fl, input logic v, input logic [4:0] r,
                       input logic rw, input logic [1:0] src, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] pc, input logic [31:0] im,
                       input logic e_v, input logic e_we, input logic [4:0] e_rd,
                       input logic [31:0] e_data, input string tag);
      exp_t e;
      @(negedge clk);
      stall = st; flush = fl; in_valid = v; rd = r; regWrite = rw; resultSrc = src;
      alu_result = alu; mem_RD = mem; pc_plus4 = pc; imm = im;
      if (!fl && !st && v) exp_cnt = exp_cnt + 32'd1;
      e.valid = e_v; e.we = e_we; e.rd = e_rd; e.data = e_data; e.tag = tag;
`ifdef WB_RETIRE_CNT_EN
      e.cnt = exp_cnt;
`else
      e.cnt = 32'd0;
`endif
      sb_q.push_back(e);
   endtask

   // Monitor: WB presents a new state after every edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({e.tag, ".valid"}, {31'd0, wb_valid}, {31'd0, e.valid});
            chk({e.tag, ".we"},    {31'd0, wb_we},    {31'd0, e.we});
            chk({e.tag, ".rd"},    {27'd0, wb_rd},    {27'd0, e.rd});
            chk({e.tag, ".data"},  wb_data,           e.data);
            chk({e.tag, ".fwd_en"},   {31'd0, fwd_en}, {31'd0, e.we});
            chk({e.tag, ".fwd_rd"},   {27'd0, fwd_rd}, {27'd0, e.rd});
            chk({e.tag, ".fwd_data"}, fwd_data,        e.data);
            chk({e.tag, ".cnt"},   retire_cnt,        e.cnt);
            $display("txn %s: valid=%0d we=%0d rd=%0d data=%h cnt=%0d",
                     e.tag, wb_valid, wb_we, wb_rd, wb_data, retire_cnt);
         end
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, ".valid"}, {31'd0, wb_valid}, 32'd0);
      chk({tag, ".we"},    {31'd0, wb_we},    32'd0);
      chk({tag, ".rd"},    {27'd0, wb_rd},    32'd0);
      chk({tag, ".data"},  wb_data,           32'd0);
      chk({tag, ".fwd_en"},   {31'd0, fwd_en}, 32'd0);
      chk({tag, ".fwd_data"}, fwd_data,        32'd0);
      chk({tag, ".cnt"},   retire_cnt,        32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      stall = 0; flush = 0; in_valid = 0; rd = 0; regWrite = 0; resultSrc = 0;
      alu_result = 0; mem_RD = 0; pc_plus4 = 0; imm = 0;

      // Reset held with random inputs across several edges.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         stall = 1'($urandom); flush = 1'($urandom); in_valid = 1'($urandom);
         rd = 5'($urandom); regWrite = 1'($urandom); resultSrc = 2'($urandom);
         alu_result = $urandom; mem_RD = $urandom; pc_plus4 = $urandom; imm = $urandom;
      end
      @(negedge clk);
      chk_zero("reset");
      stall = 1'b1; flush = 1'b0; in_valid = 1'b0;
      rst_n = 1'b1;
      exp_cnt = 0;

      //   st fl v  rd  rw src alu           mem           pc            imm            exp: v we rd data
      step(0, 0, 1, 5,  1, 0, 32'h12345678, 32'h0,        32'h0,        32'h0,         1, 1, 5, 32'h12345678, "alu");
      step(0, 0, 1, 6,  1, 1, 32'h11111111, 32'hFFFFFF80, 32'h22222222, 32'h33333333,  1, 1, 6, 32'hFFFFFF80, "mem");
      step(0, 0, 1, 7,  1, 2, 32'h11111111, 32'h44444444, 32'h00000104, 32'h33333333,  1, 1, 7, 32'h00000104, "pc4");
      step(0, 0, 1, 8,  1, 3, 32'h11111111, 32'h44444444, 32'h22222222, 32'hABCDE000,  1, 1, 8, 32'hABCDE000, "imm");
      step(0, 0, 1, 0,  1, 0, 32'h0000DEAD, 32'h0,        32'h0,        32'h0,         1, 0, 0, 32'h0000DEAD, "x0");
      step(0, 0, 0, 3,  1, 0, 32'h00000033, 32'h0,        32'h0,        32'h0,         0, 0, 3, 32'h00000033, "invalid");
      step(0, 0, 1, 7,  1, 0, 32'h00000055, 32'h0,        32'h0,        32'h0,         1, 1, 7, 32'h00000055, "cap7");
      step(1, 0, 1, 9,  1, 0, 32'h00000099, 32'h0,        32'h0,        32'h0,         1, 1, 7, 32'h00000055, "stall1");
      step(1, 0, 1, 10, 1, 1, 32'h0,        32'h000000AA, 32'h0,        32'h0,         1, 1, 7, 32'h00000055, "stall2");
      step(1, 0, 0, 11, 0, 3, 32'h0,        32'h0,        32'h0,        32'hFFFFFFFF,  1, 1, 7, 32'h00000055, "stall3");
      step(1, 1, 1, 9,  1, 0, 32'h00000099, 32'h0,        32'h0,        32'h0,         0, 0, 0, 32'h00000000, "flush_stall");
      step(0, 0, 1, 4,  0, 0, 32'h00000044, 32'h0,        32'h0,        32'h0,         1, 0, 4, 32'h00000044, "no_rw");
      step(0, 0, 1, 10, 1, 0, 32'h000000A5, 32'h0,        32'h0,        32'h0,         1, 1, 10, 32'h000000A5, "pre_arst");

      // Reset asserted between edges must clear the outputs without a clock edge.
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_zero("async_reset");
      stall = 1'b1; flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 0;

      // Ten instructions with two stall edges and one flushed instruction retire nine.
      for (int i = 1; i <= 10; i++) begin
         if (i == 4 || i == 7)
            step(1, 0, 1, 5'(i), 1, 0, 32'(i), 0, 0, 0, 1, 1, 5'(i - 1), 32'(i - 1), "cnt_stall");
         if (i == 9)
            step(0, 1, 1, 5'(i), 1, 0, 32'(i), 0, 0, 0, 0, 0, 0, 32'h0, "cnt_flush");
         else
            step(0, 0, 1, 5'(i), 1, 0, 32'(i), 0, 0, 0, 1, 1, 5'(i), 32'(i), "cnt_run");
      end

`ifdef WB_RETIRE_CNT_EN
      // Preload the counter to all-ones so the next retiring edge wraps it to zero.
      @(posedge clk);
      #2;
      force dut.retire_cnt_reg = 32'hFFFFFFFF;
      #1;
      release dut.retire_cnt_reg;
      exp_cnt = 32'hFFFFFFFF;
      step(0, 0, 1, 2, 1, 0, 32'h00000077, 0, 0, 0, 1, 1, 2, 32'h00000077, "cnt_wrap");
`endif

      // Drain the scoreboard within a bounded number of edges.
      repeat (4) @(posedge clk);
      #2;
      if (sb_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain left=%0d want=0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and write-back select for the 5-stage RISC-V core; sits directly downstream of the memory stage and consumes its load-formatted read data.
- Captures the MEM-stage results and selects the write-back value among ALU result, load data, PC+4 and immediate.
- Drives the register-file write port and the WB→EX forwarding bus.
- Supports pipeline stall (hold) and flush (bubble).

Parameters:
- DATA, 32, datapath width
- REG_ADDR, 5, register index width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hold current WB contents
- flush  input  1  replace captured entry with bubble
- in_valid  input  1  MEM stage holds a real instruction
- mem_RD  input  DATA  load data from MEM stage, already sign/zero formatted
- alu_result  input  DATA  EX result forwarded through MEM
- pc_plus4  input  DATA  link address for JAL/JALR
- imm  input  DATA  immediate for LUI
- rd  input  REG_ADDR  destination register
- regWrite  input  1  instruction writes rd
- resultSrc  input  2  00 ALU, 01 MEM, 10 PC+4, 11 IMM
- wb_valid  output  1  WB holds a real instruction
- wb_we  output  1  register-file write enable
- wb_rd  output  REG_ADDR  register-file write address
- wb_data  output  DATA  register-file write data
- fwd_en  output  1  forwarding bus valid (equals wb_we)
- fwd_rd  output  REG_ADDR  forwarding destination
- fwd_data  output  DATA  forwarding value (equals wb_data)
- retire_cnt  output  32  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (rst_n=0, asynchronous): all registered state cleared.
  - wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, fwd_*=0, retire_cnt=0.
  - Release is synchronous to the next clk edge.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on the wb_* outputs after edge N.
- Write-back select is done before the register, so wb_data is a flop output with no combinational path from inputs.
  - resultSrc 00→alu_result, 01→mem_RD, 10→pc_plus4, 11→imm.
- Per-edge priority:
  - flush=1: capture bubble (valid=0, we=0, rd=0, data=0). flush beats stall.
  - else stall=1: all registers hold their values, including retire_cnt.
  - else: capture valid=in_valid, we=in_valid & regWrite & (rd!=0), rd, selected data.
- x0 rule: rd=0 never asserts wb_we. wb_data still captures the selected value; wb_rd=0.
- in_valid=0 with regWrite=1: wb_we=0.
- Forwarding bus: fwd_en/fwd_rd/fwd_data are wired to wb_we/wb_rd/wb_data. The hazard unit compares fwd_rd against EX sources.
- Held outputs during stall remain stable. The register file may be rewritten with the same value; this is benign.
- Reset asserted mid-stall or mid-flush: reset wins immediately and asynchronously.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined:
  - retire_cnt is a 32-bit counter that increments on each non-stalled, non-flushed edge where in_valid=1.
  - Wraps 0xFFFFFFFF→0.
  - Cleared by reset.
- Undefined: retire_cnt is tied to 0 and no counter flops are synthesised.

Test Plan:
- Reset: hold rst_n=0 with random inputs, toggle clk → all outputs 0. Release, then drive in_valid=1, regWrite=1, rd=5, resultSrc=00, alu_result=0x12345678 → next cycle wb_we=1, wb_rd=5, wb_data=0x12345678.
- Source select: in consecutive cycles apply resultSrc=01 with mem_RD=0xFFFFFF80, then 10 with pc_plus4=0x00000104, then 11 with imm=0xABCDE000 → wb_data follows the same sequence, each one cycle later.
- x0 / invalid: rd=0 with regWrite=1, then in_valid=0 with rd=3 → wb_we=0 in both cycles; fwd_en=0.
- Stall then flush: capture rd=7, data=0x55, then stall=1 for 3 cycles with new inputs → outputs hold rd=7, 0x55. Then flush=1 and stall=1 together → next cycle wb_valid=0, wb_we=0, wb_rd=0, wb_data=0.
- Async reset mid-operation: assert rst_n=0 between clock edges while wb_we=1 → outputs clear without waiting for a clock edge.
- WB_RETIRE_CNT_EN:
  - Defined: 10 valid instructions with 2 stalls and 1 flush among them → retire_cnt=9.
  - Defined, wrap: preload near max via a sequence of 0xFFFFFFFF valid edges (or a force in the bench) → next valid edge gives 0.
  - Undefined: retire_cnt stays 0 throughout.
